// File: rtl/shift_engine.sv
// Register-mapped barrel-less shifter: one bit position per cycle, done after amount+1 cycles.
// CTRL/OPERAND writes while busy are dropped and flagged as overrun; reads are combinational.
module shift_engine #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             we,
  input  logic [1:0]       reg_sel,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             irq
);

  localparam logic [1:0] SEL_CTRL   = 2'b00;
  localparam logic [1:0] SEL_OPER   = 2'b01;
  localparam logic [1:0] SEL_RESULT = 2'b10;
  localparam logic [1:0] SEL_STATUS = 2'b11;
  localparam logic [SHW-1:0] CNT_ONE = 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   amount_q;
  logic [1:0]       mode_q;
  logic             ie_q;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic             done_q;
  logic             ovr_q;
  logic [WIDTH-1:0] shifted;
  logic             wr_ctrl, wr_oper, wr_stat, start;

  assign wr_ctrl = cs && we && (reg_sel == SEL_CTRL);
  assign wr_oper = cs && we && (reg_sel == SEL_OPER);
  assign wr_stat = cs && we && (reg_sel == SEL_STATUS);
  assign start   = wr_ctrl && data_in[SHW+2];

  always_comb begin
    shifted = work_q;
    case (mode_q)
      2'b00: shifted = {work_q[WIDTH-2:0], 1'b0};
      2'b01: shifted = {1'b0, work_q[WIDTH-1:1]};
      2'b10: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      2'b11: shifted = {work_q[0], work_q[WIDTH-1:1]};
      default: shifted = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amount_q  <= '0;
      mode_q    <= '0;
      ie_q      <= 1'b0;
      operand_q <= '0;
      result_q  <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= done_q & ie_q;
      if (state_q == IDLE) begin
        if (wr_ctrl) begin
          amount_q <= data_in[SHW-1:0];
          mode_q   <= data_in[SHW+1:SHW];
          ie_q     <= data_in[SHW+3];
        end
        if (start) begin
          work_q <= operand_q;
          cnt_q  <= data_in[SHW-1:0];
          done_q <= 1'b0;
          ovr_q  <= 1'b0;
        end
        if (wr_oper) operand_q <= data_in;
        if (wr_stat) begin
          done_q <= 1'b0;
          ovr_q  <= 1'b0;
        end
      end else begin
        // done is already clear while shifting, so a STATUS write only touches overrun
        if (wr_ctrl || wr_oper) ovr_q <= 1'b1;
        if (wr_stat)            ovr_q <= 1'b0;
        if (cnt_q != '0) begin
          work_q <= shifted;
          cnt_q  <= cnt_q - CNT_ONE;
        end else begin
          result_q <= work_q;
          done_q   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_out = '0;
    case (reg_sel)
      SEL_CTRL: begin
        data_out[SHW-1:0]   = amount_q;
        data_out[SHW+1:SHW] = mode_q;
        data_out[SHW+3]     = ie_q;
      end
      SEL_OPER:   data_out = operand_q;
      SEL_RESULT: data_out = result_q;
      SEL_STATUS: begin
        data_out[0] = (state_q == SHIFT);
        data_out[1] = done_q;
        data_out[2] = ovr_q;
      end
      default: data_out = '0;
    endcase
  end

endmodule

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter WIDTH, default 16, data and shift width; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount field width; SHALL not be overridden.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (active at 0).
REQ-005 cs  input  1  chip select; no register write or side effect SHALL occur when cs=0.
REQ-006 we  input  1  write enable, qualified by cs.
REQ-007 reg_sel  input  2  register select: 00 CTRL, 01 OPERAND, 10 RESULT, 11 STATUS.
REQ-008 data_in  input  WIDTH  write data.
REQ-009 data_out  output  WIDTH  combinational read mux of the selected register, valid regardless of cs.
REQ-010 irq  output  1  registered interrupt, equals done AND ie.

Function
REQ-011 CTRL fields: [SHW-1:0] amount, [SHW+1:SHW] mode (00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right), [SHW+2] start, [SHW+3] ie; other bits SHALL read 0.
REQ-012 start SHALL be self-clearing: stored and read back as 0.
REQ-013 OPERAND SHALL be a WIDTH-bit read/write register.
REQ-014 RESULT SHALL be read-only and hold the last completed result; writes to it SHALL be ignored.
REQ-015 STATUS read: bit0 busy, bit1 done, bit2 overrun, others 0; any write to STATUS SHALL clear done and overrun.
REQ-016 FSM states: IDLE, SHIFT. In IDLE, a CTRL write with start=1 SHALL latch OPERAND into a working register, latch amount into a down-counter, clear done and overrun, and enter SHIFT.
REQ-017 In SHIFT, while the counter is nonzero, each cycle SHALL shift the working register one position per mode and decrement the counter.
REQ-018 In SHIFT, when the counter is 0, the cycle SHALL copy the working register to RESULT, set done, and return to IDLE.
REQ-019 Latency: done SHALL be observed amount+1 cycles after the starting write edge; amount=0 SHALL give RESULT=OPERAND after 1 cycle.
REQ-020 Shift fill: logical modes shift in 0; arithmetic right replicates bit WIDTH-1; rotate right moves bit 0 into bit WIDTH-1.
REQ-021 busy SHALL be 1 exactly while in SHIFT.
REQ-022 While busy, writes to CTRL or OPERAND SHALL be discarded and SHALL set overrun; a STATUS write while busy SHALL clear overrun but not affect the operation.
REQ-023 A STATUS write in the same cycle as completion: done SHALL end 1 (completion wins); overrun SHALL clear.
REQ-024 A CTRL write with start=0 in IDLE SHALL update amount/mode/ie only.
REQ-025 A start while done=1 SHALL be accepted, and done SHALL clear on the start edge.
REQ-026 irq SHALL assert the cycle after done&ie becomes 1 and deassert the cycle after either clears.

Reset
REQ-027 reset=0 SHALL asynchronously force: IDLE state, CTRL=0, OPERAND=0, RESULT=0, working register=0, counter=0, busy=0, done=0, overrun=0, irq=0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation; RESULT SHALL stay 0 after release and no done SHALL be produced.
REQ-029 After reset release, the block SHALL accept a start on the first clock edge.

Verification
REQ-030 WIDTH=16: OPERAND=0x8001, CTRL amount=4 mode=00 start -> busy for 5 cycles, RESULT=0x0010, done=1.
REQ-031 OPERAND=0x8001, amount=4, mode=10 -> RESULT=0xF800; mode=11 -> RESULT=0x1800; mode=01 -> RESULT=0x0800.
REQ-032 amount=0, any mode, OPERAND=0xA5A5 -> done after 1 cycle, RESULT=0xA5A5.
REQ-033 Start with amount=15, then write OPERAND=0x1234 on cycle 3 -> overrun=1, RESULT computed from the original operand; STATUS write -> done=0, overrun=0.
REQ-034 ie=1, amount=2 -> irq=1 one cycle after done; STATUS write -> irq=0 next cycle.
REQ-035 Start amount=10, assert reset on cycle 4 -> all outputs 0 immediately; after release, STATUS reads 0.
